child_resp_collector: RTL
=========================

CHILD_RESP_COLLECTOR -- requirements
Module: child_resp_collector

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the width of each child response word.
REQ-002 The block SHALL have parameter NUM_CHILD, default 5, giving the number of child ports; the legal range is 2..8.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-005 The block SHALL have port c_valid, input, NUM_CHILD bits: per-child response valid.
REQ-006 The block SHALL have port c_data, input, NUM_CHILD*DATA_W bits: per-child response data; child i occupies bits [i*DATA_W +: DATA_W].
REQ-007 The block SHALL have port c_ready, output, NUM_CHILD bits: per-child accept.
REQ-008 The block SHALL have port p_valid, output, 1 bit: merged response valid toward the parent.
REQ-009 The block SHALL have port p_data, output, DATA_W bits: merged response data.
REQ-010 The block SHALL have port p_src, output, 3 bits: index of the child that produced p_data.
REQ-011 The block SHALL have port p_ready, input, 1 bit: parent accept.

Function
REQ-012 A transfer on child i SHALL occur when c_valid[i] and c_ready[i] are both high; a parent transfer SHALL occur when p_valid and p_ready are both high.
REQ-013 The output stage SHALL be a single register holding p_valid, p_data and p_src, with two states: EMPTY (p_valid=0) and FULL (p_valid=1).
REQ-014 The output register SHALL be loadable in a cycle when it is EMPTY, or when it is FULL and p_ready=1.
REQ-015 At most one c_ready bit SHALL be high per cycle; c_ready[i] SHALL be high only if child i is the arbitration winner and the output register is loadable.
REQ-016 The arbitration winner SHALL be the first child with c_valid high, searching upward with wrap-around from (last_grant+1) mod NUM_CHILD.
REQ-017 last_grant SHALL update to the winner index only in a cycle where a child transfer occurs.
REQ-018 The latency SHALL be one cycle: data accepted from child i in cycle N SHALL appear on p_data, with p_src=i and p_valid=1, in cycle N+1.
REQ-019 A simultaneous parent transfer and child transfer SHALL replace the output contents with no bubble, sustaining one transfer per cycle.
REQ-020 While the output is FULL and p_ready=0, p_valid, p_data and p_src SHALL hold stable and all c_ready bits SHALL be 0.
REQ-021 A parent transfer with no child transfer SHALL move the output stage to EMPTY.
REQ-022 c_ready SHALL depend combinationally only on c_valid, p_ready and internal state, never on c_data.
REQ-023 Once c_valid[i] is high, a child SHALL be granted within NUM_CHILD accepted transfers (starvation-free).

Reset
REQ-024 While rst=1, p_valid SHALL be 0, p_data 0, p_src 0, last_grant NUM_CHILD-1 and all counters 0, so child 0 has first priority after reset.
REQ-025 c_ready SHALL be all-zero during any cycle with rst=1.
REQ-026 Reset asserted while the output is FULL SHALL discard the held response, with no parent transfer counted.

Configuration
REQ-027 When macro CHILD_RESP_COLLECTOR_CNT_EN is defined, the block SHALL add output port c_cnt, NUM_CHILD*16 bits, holding one 16-bit per-child count of accepted transfers.
REQ-028 Each c_cnt count SHALL saturate at 16'hFFFF, SHALL update one cycle after the transfer, and SHALL clear on reset.
REQ-029 When CHILD_RESP_COLLECTOR_CNT_EN is not defined, the c_cnt port and its counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 After reset, c_valid=5'b00100 with c_data[2]=8'hA5 and p_ready=1 -> the next cycle shows p_valid=1, p_data=8'hA5, p_src=2.
REQ-031 c_valid=5'b11111 held high with p_ready=1 for 10 cycles -> p_src sequence is 0,1,2,3,4,0,1,2,3,4 with no idle cycle.
REQ-032 Output FULL with p_ready=0 for 4 cycles and c_valid=5'b00011 -> c_ready=0 throughout and p_data stable; when p_ready rises, the transfer and refill occur in the same cycle.
REQ-033 rst pulsed for 1 cycle while the output holds 8'h3C -> p_valid=0 the next cycle, and the first subsequent grant goes to the lowest valid index.
REQ-034 With CHILD_RESP_COLLECTOR_CNT_EN defined and child 1 sending 70000 transfers -> c_cnt[1] reads 16'hFFFF and the other counts read 0.
REQ-035 Constrained-random c_valid and p_ready over 10k cycles -> a scoreboard shows no loss, duplication or reordering per child, and no child waits more than 5 grants.

Source files
------------

// File: rtl/child_resp_collector.sv
// Round-robin collector merging NUM_CHILD child response streams into one registered parent stream.
// Optional per-child accept counters (c_cnt) are built when CHILD_RESP_COLLECTOR_CNT_EN is defined.
module child_resp_collector #(
  parameter int DATA_W    = 8,
  parameter int NUM_CHILD = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CHILD-1:0]          c_valid,
  input  logic [NUM_CHILD*DATA_W-1:0]   c_data,
  output logic [NUM_CHILD-1:0]          c_ready,
  output logic                          p_valid,
  output logic [DATA_W-1:0]             p_data,
  output logic [2:0]                    p_src,
  input  logic                          p_ready
`ifdef CHILD_RESP_COLLECTOR_CNT_EN
  ,
  output logic [NUM_CHILD*16-1:0]       c_cnt
`endif
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_CHILD - 1);
  localparam logic [3:0] NUM_C4   = 4'(NUM_CHILD);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t              state_r;
  logic [DATA_W-1:0]   p_data_r;
  logic [2:0]          p_src_r;
  logic [2:0]          last_grant_r;

  logic                loadable_s;
  logic                found_s;
  logic [2:0]          winner_s;
  logic                xfer_s;
  logic [DATA_W-1:0]   sel_data_s;

  // (idx + step) mod NUM_CHILD; idx < NUM_CHILD and step <= NUM_CHILD, so one subtraction suffices
  function automatic logic [2:0] wrap_add(input logic [2:0] idx, input logic [3:0] step);
    logic [3:0] sum;
    sum = {1'b0, idx} + step;
    if (sum >= NUM_C4) begin
      sum = sum - NUM_C4;
    end else begin
      sum = sum;
    end
    return sum[2:0];
  endfunction

  assign loadable_s = !rst && ((state_r == EMPTY) || p_ready);

  // Round-robin search starting just after the last granted child
  always_comb begin
    found_s  = 1'b0;
    winner_s = 3'd0;
    for (int k = 1; k <= NUM_CHILD; k++) begin
      if (!found_s && c_valid[wrap_add(last_grant_r, 4'(k))]) begin
        found_s  = 1'b1;
        winner_s = wrap_add(last_grant_r, 4'(k));
      end else begin
        found_s  = found_s;
        winner_s = winner_s;
      end
    end
  end

  // One-hot accept to the winner, only when the output register can take it
  always_comb begin
    c_ready = {NUM_CHILD{1'b0}};
    if (loadable_s && found_s) begin
      c_ready[winner_s] = 1'b1;
    end else begin
      c_ready = {NUM_CHILD{1'b0}};
    end
  end

  assign xfer_s = |c_ready;

  // Data mux for the winning child
  always_comb begin
    sel_data_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_CHILD; i++) begin
      if (winner_s == 3'(i)) begin
        sel_data_s = c_data[i*DATA_W +: DATA_W];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Output stage FSM: holds the merged response and tracks the last grant
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= EMPTY;
      p_data_r     <= {DATA_W{1'b0}};
      p_src_r      <= 3'd0;
      last_grant_r <= LAST_IDX;
    end else begin
      case (state_r)
        EMPTY: begin
          if (xfer_s) begin
            state_r      <= FULL;
            p_data_r     <= sel_data_s;
            p_src_r      <= winner_s;
            last_grant_r <= winner_s;
          end else begin
            state_r      <= EMPTY;
          end
        end
        FULL: begin
          if (xfer_s) begin
            // parent drain and refill in the same cycle: no bubble
            state_r      <= FULL;
            p_data_r     <= sel_data_s;
            p_src_r      <= winner_s;
            last_grant_r <= winner_s;
          end else if (p_ready) begin
            state_r      <= EMPTY;
          end else begin
            state_r      <= FULL;
          end
        end
        default: begin
          state_r      <= EMPTY;
          p_data_r     <= {DATA_W{1'b0}};
          p_src_r      <= 3'd0;
          last_grant_r <= LAST_IDX;
        end
      endcase
    end
  end

  assign p_valid = (state_r == FULL);
  assign p_data  = p_data_r;
  assign p_src   = p_src_r;

`ifdef CHILD_RESP_COLLECTOR_CNT_EN
  logic [15:0] cnt_r [NUM_CHILD];

  // Saturating per-child accept counters
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHILD; i++) begin
        cnt_r[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < NUM_CHILD; i++) begin
        if (c_ready[i] && (cnt_r[i] != 16'hFFFF)) begin
          cnt_r[i] <= cnt_r[i] + 16'd1;
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CHILD; g++) begin : g_cnt
    assign c_cnt[g*16 +: 16] = cnt_r[g];
  end
`endif

endmodule
